// File: rtl/bdmac_multi.sv
// Buzzer DMA register block: NCH playback channels behind a zero-wait AHB-Lite slave.
// Channels count down hardware loops on ref pulses and latch sticky done flags into one maskable irq.
module bdmac_multi #(
    parameter int NCH   = 4,
    parameter int AW    = 32,
    parameter int LOOPW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_hsel,
    input  logic               i_hwrite,
    input  logic               i_hready,
    input  logic [1:0]         i_htrans,
    input  logic [31:0]        i_haddr,
    input  logic [31:0]        i_hwdata,
    output logic [31:0]        o_hrdata,
    output logic               o_hreadyout,
    input  logic [NCH-1:0]     i_ref,
    output logic [NCH*AW-1:0]  o_start_addr,
    output logic [2*NCH-1:0]   o_pri,
    output logic [NCH-1:0]     o_cyclic,
    output logic [NCH-1:0]     o_playing,
    output logic [NCH-1:0]     o_stop,
    output logic               o_irq
);

    logic             r_vld;
    logic             r_wr;
    logic [11:2]      r_addr;

    logic [AW-1:0]    r_start [NCH];
    logic [1:0]       r_pri   [NCH];
    logic [LOOPW-1:0] r_loop  [NCH];
    logic [LOOPW-1:0] r_rem   [NCH];
    logic [NCH-1:0]   r_stop;
    logic [NCH-1:0]   r_playing;
    logic [NCH-1:0]   r_cyclic;
    logic [NCH-1:0]   r_done;
    logic [NCH-1:0]   r_irq_en;

    logic             w_acc;
    logic             w_wen;
    logic             w_chsel;
    logic [3:0]       w_ch;
    logic [1:0]       w_off;
    logic             w_irqen_wr;
    logic [NCH-1:0]   w_start_wr;
    logic [NCH-1:0]   w_ctrl_wr;
    logic [NCH-1:0]   w_stat_wr;
    logic [NCH-1:0]   w_fin;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_acc      = i_hsel & i_hready & i_htrans[1];
    assign w_wen      = r_vld & r_wr;
    assign w_chsel    = (r_addr[11:8] == 4'h0);
    assign w_ch       = r_addr[7:4];
    assign w_off      = r_addr[3:2];
    assign w_irqen_wr = w_wen && (r_addr == 10'h3FC);
    assign w_unused   = &{1'b0, i_htrans[0], i_haddr[31:12], i_haddr[1:0], i_hwdata};

    always_comb begin
        w_start_wr = '0;
        w_ctrl_wr  = '0;
        w_stat_wr  = '0;
        w_fin      = '0;
        for (int c = 0; c < NCH; c++) begin
            w_start_wr[c] = w_wen && w_chsel && (w_ch == 4'(c)) && (w_off == 2'd0);
            w_ctrl_wr[c]  = w_wen && w_chsel && (w_ch == 4'(c)) && (w_off == 2'd1);
            w_stat_wr[c]  = w_wen && w_chsel && (w_ch == 4'(c)) && (w_off == 2'd2);
            // A CTRL write in the same cycle swallows the ref entirely.
            w_fin[c] = i_ref[c] && r_playing[c] && !w_ctrl_wr[c] &&
                       (!r_cyclic[c] || (r_rem[c] == LOOPW'(1)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_wr   <= 1'b0;
            r_addr <= '0;
        end else if (i_hready) begin
            r_vld  <= w_acc;
            r_wr   <= i_hwrite;
            r_addr <= i_haddr[11:2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stop    <= '0;
            r_playing <= '0;
            r_cyclic  <= '0;
            r_done    <= '0;
            r_irq_en  <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_start[c] <= '0;
                r_pri[c]   <= '0;
                r_loop[c]  <= '0;
                r_rem[c]   <= '0;
            end
        end else begin
            if (w_irqen_wr) begin
                r_irq_en <= i_hwdata[NCH-1:0];
            end
            for (int c = 0; c < NCH; c++) begin
                if (w_start_wr[c]) begin
                    r_start[c] <= i_hwdata[AW-1:0];
                end
                if (w_ctrl_wr[c]) begin
                    r_stop[c]    <= i_hwdata[0];
                    r_playing[c] <= i_hwdata[1];
                    r_cyclic[c]  <= i_hwdata[2];
                    r_pri[c]     <= i_hwdata[4:3];
                    r_loop[c]    <= i_hwdata[8 +: LOOPW];
                    r_rem[c]     <= i_hwdata[1] ? i_hwdata[8 +: LOOPW] : '0;
                end else if (i_ref[c] && r_playing[c]) begin
                    if (!r_cyclic[c]) begin
                        r_playing[c] <= 1'b0;
                    end else if (r_rem[c] == LOOPW'(1)) begin
                        r_playing[c] <= 1'b0;
                        r_rem[c]     <= '0;
                    end else if (r_rem[c] != '0) begin
                        r_rem[c] <= r_rem[c] - LOOPW'(1);
                    end
                end
                if (w_fin[c]) begin
                    r_done[c] <= 1'b1;
                end else if (w_stat_wr[c] && i_hwdata[16]) begin
                    r_done[c] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (r_vld) begin
            if (w_chsel) begin
                for (int c = 0; c < NCH; c++) begin
                    if (w_ch == 4'(c)) begin
                        case (w_off)
                            2'd0: w_rdata[AW-1:0] = r_start[c];
                            2'd1: begin
                                w_rdata[0]          = r_stop[c];
                                w_rdata[1]          = r_playing[c];
                                w_rdata[2]          = r_cyclic[c];
                                w_rdata[4:3]        = r_pri[c];
                                w_rdata[8 +: LOOPW] = r_loop[c];
                            end
                            2'd2: begin
                                w_rdata[LOOPW-1:0] = r_rem[c];
                                w_rdata[16]        = r_done[c];
                            end
                            default: ;
                        endcase
                    end
                end
            end else begin
                case (r_addr)
                    10'h3FC: w_rdata[NCH-1:0] = r_irq_en;
                    10'h3FD: w_rdata[NCH-1:0] = r_done & r_irq_en;
                    10'h3FE: w_rdata = {16'hBD0A, 8'(NCH), 8'(LOOPW)};
                    default: ;
                endcase
            end
        end
    end

    assign o_hrdata    = w_rdata;
    assign o_hreadyout = 1'b1;
    assign o_cyclic    = r_cyclic;
    assign o_playing   = r_playing;
    assign o_stop      = r_stop;
    assign o_irq       = |(r_done & r_irq_en);

    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign o_start_addr[g*AW +: AW] = r_start[g];
        assign o_pri[2*g +: 2]          = r_pri[g];
    end

endmodule

// File: tb/tb_bdmac_multi.sv
// Directed bench for bdmac_multi: register map vectors plus loop, irq and collision sequences.
module tb_bdmac_multi;

    localparam int NCH   = 4;
    localparam int AW    = 32;
    localparam int LOOPW = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              hsel = 1'b0;
    logic              hwrite = 1'b0;
    logic              hready = 1'b1;
    logic [1:0]        htrans = 2'b00;
    logic [31:0]       haddr = '0;
    logic [31:0]       hwdata = '0;
    logic [31:0]       hrdata;
    logic              hreadyout;
    logic [NCH-1:0]    refp = '0;
    logic [NCH*AW-1:0] start_addr;
    logic [2*NCH-1:0]  pri;
    logic [NCH-1:0]    cyclic;
    logic [NCH-1:0]    playing;
    logic [NCH-1:0]    stop;
    logic              irq;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] dat;
    } vec_t;

    vec_t tbl [$];

    bdmac_multi #(.NCH(NCH), .AW(AW), .LOOPW(LOOPW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_hsel       (hsel),
        .i_hwrite     (hwrite),
        .i_hready     (hready),
        .i_htrans     (htrans),
        .i_haddr      (haddr),
        .i_hwdata     (hwdata),
        .o_hrdata     (hrdata),
        .o_hreadyout  (hreadyout),
        .i_ref        (refp),
        .o_start_addr (start_addr),
        .o_pri        (pri),
        .o_cyclic     (cyclic),
        .o_playing    (playing),
        .o_stop       (stop),
        .o_irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp_v);
        end
    endtask

    // Address phase on one cycle, data (and optional ref pulse) on the next.
    task automatic ahb_wr(input logic [11:0] a, input logic [31:0] d, input logic [NCH-1:0] rf);
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = {20'h0, a};
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d; refp = rf;
        @(negedge clk);
        refp = '0;
    endtask

    task automatic ahb_rd(input logic [11:0] a, output logic [31:0] d);
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = {20'h0, a};
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00;
        d = hrdata;
    endtask

    task automatic pulse(input logic [NCH-1:0] m);
        @(negedge clk);
        refp = m;
        @(negedge clk);
        refp = '0;
    endtask

    initial begin
        logic [31:0] rd;

        repeat (3) @(negedge clk);
        check("rst_hreadyout", {31'b0, hreadyout}, 32'h1);
        check("rst_start_addr", 32'(start_addr != '0), 32'h0);
        check("rst_ctrl_outs", {16'b0, pri, cyclic, playing}, 32'h0);
        check("rst_stop_irq", {27'b0, stop, irq}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        tbl.push_back({1'b0, 12'hFF8, 32'hBD0A0408});
        tbl.push_back({1'b1, 12'h020, 32'h00001234});
        tbl.push_back({1'b0, 12'h020, 32'h00001234});
        tbl.push_back({1'b0, 12'h024, 32'h00000000});
        tbl.push_back({1'b1, 12'h028, 32'hFFFFFFFF});
        tbl.push_back({1'b0, 12'h028, 32'h00000000});
        tbl.push_back({1'b1, 12'h100, 32'h00000005});
        tbl.push_back({1'b0, 12'h100, 32'h00000000});
        tbl.push_back({1'b0, 12'h040, 32'h00000000});
        tbl.push_back({1'b0, 12'h00C, 32'h00000000});
        tbl.push_back({1'b1, 12'hFF0, 32'hFFFFFFFF});
        tbl.push_back({1'b0, 12'hFF0, 32'h0000000F});
        tbl.push_back({1'b1, 12'hFF0, 32'h00000000});
        tbl.push_back({1'b1, 12'h000, 32'hFFFFFFFF});
        tbl.push_back({1'b0, 12'h000, 32'hFFFFFFFF});
        tbl.push_back({1'b1, 12'h000, 32'h00000000});
        tbl.push_back({1'b0, 12'hFF4, 32'h00000000});
        tbl.push_back({1'b1, 12'h034, 32'hFFFF551B});
        tbl.push_back({1'b0, 12'h034, 32'h0000551B});
        tbl.push_back({1'b0, 12'h038, 32'h00000055});

        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                ahb_wr(tbl[i].addr, tbl[i].dat, '0);
            end else begin
                ahb_rd(tbl[i].addr, rd);
                check($sformatf("tbl[%0d] rd 0x%03h", i, tbl[i].addr), rd, tbl[i].dat);
            end
        end

        check("ch2_start_out", start_addr[2*AW +: AW], 32'h1234);
        check("ch3_ctrl_outs", {28'b0, pri[7:6], stop[3], playing[3]}, 32'hF);
        check("ch3_cyclic_out", {31'b0, cyclic[3]}, 32'h0);
        ahb_wr(12'h034, 32'h0000551B & ~32'h2, '0);
        ahb_rd(12'h038, rd);
        check("ch3_stop_clears_rem", rd, 32'h0);
        ahb_wr(12'h034, 32'h0, '0);

        // Cyclic loop of 3 counts down to completion.
        ahb_wr(12'h004, 32'h306, '0);
        check("ch0_playing_cyclic", {30'b0, cyclic[0], playing[0]}, 32'h3);
        pulse(4'b0001);
        ahb_rd(12'h008, rd);
        check("ch0_rem_after1", rd, 32'h2);
        pulse(4'b0001);
        ahb_rd(12'h008, rd);
        check("ch0_rem_after2", rd, 32'h1);
        pulse(4'b0001);
        ahb_rd(12'h008, rd);
        check("ch0_stat_after3", rd, 32'h10000);
        check("ch0_stopped", {31'b0, playing[0]}, 32'h0);
        check("irq_masked", {31'b0, irq}, 32'h0);

        // Loop count 0 in cyclic mode runs forever.
        ahb_wr(12'h014, 32'h006, '0);
        @(negedge clk);
        refp = 4'b0010;
        repeat (10) @(negedge clk);
        refp = '0;
        check("ch1_infinite_playing", {31'b0, playing[1]}, 32'h1);
        ahb_rd(12'h018, rd);
        check("ch1_infinite_stat", rd, 32'h0);

        ahb_wr(12'hFF0, 32'h1, '0);
        check("irq_on_enable", {31'b0, irq}, 32'h1);
        ahb_rd(12'hFF4, rd);
        check("irq_pend", rd, 32'h1);
        ahb_wr(12'h008, 32'h10000, '0);
        check("irq_after_w1c", {31'b0, irq}, 32'h0);

        // Done from a ref wins over a simultaneous W1C.
        ahb_wr(12'h004, 32'h002, '0);
        ahb_wr(12'h008, 32'h10000, 4'b0001);
        check("w1c_vs_ref_irq", {31'b0, irq}, 32'h1);
        ahb_rd(12'h008, rd);
        check("w1c_vs_ref_stat", rd, 32'h10000);
        check("w1c_vs_ref_playing", {31'b0, playing[0]}, 32'h0);
        ahb_wr(12'h008, 32'h10000, '0);
        check("w1c_clear_irq", {31'b0, irq}, 32'h0);

        // CTRL write beats a ref on the same channel.
        ahb_wr(12'h034, 32'h002, 4'b1000);
        check("ch3_ctrl_vs_ref_play", {31'b0, playing[3]}, 32'h1);
        ahb_rd(12'h038, rd);
        check("ch3_ctrl_vs_ref_stat", rd, 32'h0);
        ahb_wr(12'h034, 32'h502, 4'b1000);
        check("ch3_reload_play", {31'b0, playing[3]}, 32'h1);
        ahb_rd(12'h038, rd);
        check("ch3_reload_stat", rd, 32'h5);

        // Pipelined write then read of the same register.
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h010;
        @(negedge clk);
        hwdata = 32'h0000ABCD; hwrite = 1'b0; haddr = 32'h010;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00;
        check("b2b_wr_rd", hrdata, 32'h0000ABCD);

        // Reset during the data phase discards the pending write.
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h030;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h55; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        ahb_rd(12'h030, rd);
        check("rst_mid_xfer_start", rd, 32'h0);
        check("rst_mid_xfer_outs", {27'b0, playing, irq}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
